// File: rtl/rgbw_frame_ctrl.sv
// RGBW frame receiver. It takes bytes from an SPI receiver whose byte-ready
// level is not aligned to ce, and parses frames of the form
// SYNC, 7 payload bytes, XOR checksum. The output fields change only on a
// successful commit, so downstream logic never sees a partial frame.
//
// Handshake: rx_rdy is a level from the SPI receiver. Each rising edge seen
// through the synchronizer is one byte, and rx_byte must be stable while
// rx_rdy is high. There is no back-pressure. Downstream sees a one-enabled-cycle
// frame_ok or frame_err pulse and never both at once.
module rgbw_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'h55,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  output logic [7:0] lint,
  output logic [7:0] color_idx,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] mode,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    COMMIT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  shadow_q [7];
  logic [7:0]  shadow_d [7];
  logic [7:0]  out_q [7];
  logic [7:0]  out_d [7];
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  pend_byte_q, pend_byte_d;

  logic        byte_ev;
  logic        idle_vld;
  logic [7:0]  idle_byte;
  logic [16:0] timer_inc;
  logic        timed_out;

  // Next-state, datapath and pulse logic; evaluated only when ce is high.
  always_comb begin
    state_d     = state_q;
    sync1_d     = rx_rdy;
    sync2_d     = sync1_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    timer_d     = timer_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    pend_vld_d  = 1'b0;
    pend_byte_d = pend_byte_q;

    byte_ev   = sync1_q & ~sync2_q;
    // A byte held over from COMMIT takes precedence. The synchronizer
    // spaces byte events at least two enabled cycles apart, so a held
    // byte and a fresh one cannot meet in the same cycle.
    idle_vld  = pend_vld_q | byte_ev;
    idle_byte = pend_vld_q ? pend_byte_q : rx_byte;
    timer_inc = {1'b0, timer_q} + 17'd1;
    timed_out = (timer_inc == {1'b0, TIMEOUT_CYC});

    case (state_q)
      IDLE: begin
        timer_d = 16'd0;
        if (idle_vld && (idle_byte == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = 3'd0;
          acc_d   = 8'h00;
        end
      end

      PAYLOAD: begin
        if (byte_ev) begin
          timer_d          = 16'd0;
          shadow_d[idx_q]  = rx_byte;
          acc_d            = acc_q ^ rx_byte;
          idx_d            = idx_q + 3'd1;
          if (idx_q == 3'd6) begin
            state_d = CHECK;
          end
        end else if (timed_out) begin
          timer_d  = 16'd0;
          err_d    = 1'b1;
          state_d  = IDLE;
          for (int i = 0; i < 7; i++) shadow_d[i] = 8'h00;
        end else begin
          timer_d = timer_inc[15:0];
        end
      end

      CHECK: begin
        if (byte_ev) begin
          timer_d = 16'd0;
          if (rx_byte == acc_q) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timed_out) begin
          timer_d  = 16'd0;
          err_d    = 1'b1;
          state_d  = IDLE;
          for (int i = 0; i < 7; i++) shadow_d[i] = 8'h00;
        end else begin
          timer_d = timer_inc[15:0];
        end
      end

      COMMIT: begin
        timer_d = 16'd0;
        out_d   = shadow_q;
        ok_d    = 1'b1;
        state_d = IDLE;
        if (byte_ev) begin
          pend_vld_d  = 1'b1;
          pend_byte_d = rx_byte;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers: synchronous active-low reset wins over ce; otherwise update only on enabled edges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      idx_q       <= 3'd0;
      acc_q       <= 8'h00;
      timer_q     <= 16'd0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_byte_q <= 8'h00;
      for (int i = 0; i < 7; i++) begin
        shadow_q[i] <= 8'h00;
        out_q[i]    <= 8'h00;
      end
    end else if (ce) begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      timer_q     <= timer_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      pend_vld_q  <= pend_vld_d;
      pend_byte_q <= pend_byte_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
    end
  end

  assign lint      = out_q[0];
  assign color_idx = out_q[1];
  assign red       = out_q[2];
  assign green     = out_q[3];
  assign blue      = out_q[4];
  assign white     = out_q[5];
  assign mode      = out_q[6];
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign busy      = (state_q == PAYLOAD) || (state_q == CHECK);
  assign state_dbg = state_q;

endmodule
